// File: rtl/serial_pair_serializer.sv
// serial_pair_serializer
// Parallel-to-serial transmitter for a bit-serial comparator. Accepts a pair
// of WIDTH-bit words over a valid/ready handshake, emits a one-cycle clear
// pulse (the comparator's synchronous reset), then shifts both words out one
// bit pair per clock, MSB first or LSB first.
//
// Ports:
//   clk        clock, all state changes on posedge
//   rst        asynchronous active-high reset
//   in_valid   producer presents a word pair on a_word/b_word
//   in_ready   pair is accepted at the posedge where in_valid & in_ready
//   a_word     parallel word A
//   b_word     parallel word B
//   clear      one-cycle pulse ahead of each word's first bit
//   a, b       serial bits, meaningful while bit_valid=1
//   bit_valid  a/b carry a data bit this cycle
//   last       final bit pair of the word
//   busy       a word is being cleared or shifted
module serial_pair_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_word,
   input  logic [WIDTH-1:0] b_word,
   output logic             clear,
   output logic             a,
   output logic             b,
   output logic             bit_valid,
   output logic             last,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic             at_last;
   logic             accept;

   // Bit that leaves the shift register next, in the configured order.
   function automatic logic head_bit(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? v[WIDTH-1] : v[0];
   endfunction

   // Shift register after the head bit has been sent.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
   endfunction

   // The final bit cycle doubles as the accept slot for the next pair, which
   // is what lets words stream with only the clear cycle between them.
   assign at_last  = (state == S_SHIFT) && (cnt == CNT_LAST);
   assign in_ready = (state == S_IDLE) || at_last;
   assign busy     = (state != S_IDLE);
   assign accept   = in_valid && in_ready;

   // All serial-side outputs are registered: each is computed one cycle ahead
   // from the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         sh_a      <= '0;
         sh_b      <= '0;
         clear     <= 1'b0;
         a         <= 1'b0;
         b         <= 1'b0;
         bit_valid <= 1'b0;
         last      <= 1'b0;
      end else begin
         clear     <= 1'b0;
         a         <= 1'b0;
         b         <= 1'b0;
         bit_valid <= 1'b0;
         last      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state <= S_CLEAR;
                  sh_a  <= a_word;
                  sh_b  <= b_word;
                  clear <= 1'b1;
               end
            end
            S_CLEAR: begin
               state     <= S_SHIFT;
               cnt       <= '0;
               bit_valid <= 1'b1;
               a         <= head_bit(sh_a);
               b         <= head_bit(sh_b);
               sh_a      <= advance(sh_a);
               sh_b      <= advance(sh_b);
            end
            S_SHIFT: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (accept) begin
                     state <= S_CLEAR;
                     sh_a  <= a_word;
                     sh_b  <= b_word;
                     clear <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  cnt       <= cnt + CNT_W'(1);
                  bit_valid <= 1'b1;
                  a         <= head_bit(sh_a);
                  b         <= head_bit(sh_b);
                  sh_a      <= advance(sh_a);
                  sh_b      <= advance(sh_b);
                  last      <= (cnt == CNT_PRE);
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
